pc_reg: RTL

- Fetch-stage program counter that drives the instruction ROM address and chip enable.
- Sits directly upstream of the IF/ID pipeline register. Its pc output goes both to the ROM and to if_id's if_pc input; if_id delays pc one cycle internally to match ROM read latency.
- Handles pipeline stall, branch redirect, and a one-entry pending-redirect buffer so a branch resolved during a fetch stall is never lost.

---
 rtl/pc_reg_if.sv | 17 +
 rtl/pc_reg.sv | 49 ++++
 2 files changed

// File: rtl/pc_reg_if.sv
// pc_reg_if: fetch-stage control and ROM address bundle between pipeline control and the PC register.
interface pc_reg_if;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] pc;
  logic        ce;
  logic        redirect_pending_o;
  modport master (
    output stall, branch_flag_i, branch_target_address_i,
    input  pc, ce, redirect_pending_o
  );
  modport slave (
    input  stall, branch_flag_i, branch_target_address_i,
    output pc, ce, redirect_pending_o
  );
endinterface

// File: rtl/pc_reg.sv
// pc_reg: fetch program counter with stall hold, branch redirect and a one-entry pending-redirect buffer.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic     clk,
  input  logic     rst,
  pc_reg_if.slave  bus
);
  typedef enum logic {BOOT, FETCH} state_t;
  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  logic        r_ce;
  logic        r_pend;
  logic [31:0] w_tgt;
  logic        w_unused;
  assign w_tgt    = {bus.branch_target_address_i[31:2], 2'b00};
  assign w_unused = ^bus.stall[5:1];
  // A branch seen while stalled is parked in r_tgt; the youngest one wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_ce    <= 1'b0;
      r_pend  <= 1'b0;
      r_tgt   <= '0;
    end else if (r_state == BOOT) begin
      r_state <= FETCH;
      r_ce    <= 1'b1;
    end else if (bus.stall[0]) begin
      if (bus.branch_flag_i) begin
        r_tgt  <= w_tgt;
        r_pend <= 1'b1;
      end
    end else if (bus.branch_flag_i) begin
      r_pc   <= w_tgt;
      r_pend <= 1'b0;
    end else if (r_pend) begin
      r_pc   <= r_tgt;
      r_pend <= 1'b0;
    end else begin
      r_pc <= r_pc + PC_STEP;
    end
  end
  assign bus.pc                 = r_pc;
  assign bus.ce                 = r_ce;
  assign bus.redirect_pending_o = r_pend;
endmodule
